// File: rtl/battle_board_ctrl.sv
// battle_board_ctrl: fleet/attack maps, shot-resolution FSM and LED/7-seg scan for a ROWS x COLS board.
// Define SHOTS_LIMIT_EN to build the MAX_SHOTS shot budget that drives the lose output.
module battle_board_ctrl #(
  parameter int ROWS      = 7,
  parameter int COLS      = 5,
  parameter int SCAN_DIV  = 1000,
  parameter int MAX_SHOTS = 20
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 button_clear,
  input  logic                 load_fleet,
  input  logic [ROWS*COLS-1:0] fleet_in,
  input  logic                 button_confirmation,
  input  logic [2:0]           coord_row,
  input  logic [2:0]           coord_col,
  output logic [1:0]           status,
  output logic                 busy,
  output logic                 win,
  output logic                 lose,
  output logic [COLS-1:0]      m_col,
  output logic [ROWS-1:0]      m_line_hit,
  output logic [ROWS-1:0]      m_line_miss,
  output logic [2:0]           dig_sel,
  output logic [3:0]           dig_val
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [3:0] ROWS_L = 4'(ROWS);
  localparam logic [3:0] COLS_L = 4'(COLS);

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_MISS = 2'b01;
  localparam logic [1:0] ST_HIT  = 2'b10;
  localparam logic [1:0] ST_REP  = 2'b11;

  typedef enum logic [1:0] {IDLE, CHECK, UPDATE, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    fleet_q, fleet_d;
  logic [N-1:0]    attack_q, attack_d;
  logic [1:0]      status_q, status_d;
  logic [1:0]      cls_q, cls_d;
  logic            busy_q, busy_d;
  logic            win_q, win_d;
  logic [7:0]      shot_cnt_q, shot_cnt_d;
  logic [2:0]      last_row_q, last_row_d;
  logic [2:0]      last_col_q, last_col_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   col_q, col_d;
  logic [1:0]      dig_q, dig_d;
`ifdef SHOTS_LIMIT_EN
  logic            lose_q, lose_d;
`endif

  logic [6:0]      sel_idx;
  logic            sel_valid;
  logic [N-1:0]    sel_mask;
  logic            shot_valid;
  logic            tick;

  // One-hot mask of the latched target cell; empty when the target is off the board.
  assign sel_idx    = 7'(last_row_q) * 7'(COLS) + 7'(last_col_q);
  assign sel_valid  = ({1'b0, last_row_q} < ROWS_L) && ({1'b0, last_col_q} < COLS_L);
  assign sel_mask   = sel_valid ? ({{(N-1){1'b0}}, 1'b1} << sel_idx) : '0;
  assign shot_valid = (cls_q != ST_REP);

  always_comb begin
    state_d    = state_q;
    fleet_d    = fleet_q;
    attack_d   = attack_q;
    status_d   = status_q;
    cls_d      = cls_q;
    busy_d     = busy_q;
    win_d      = win_q;
    shot_cnt_d = shot_cnt_q;
    last_row_d = last_row_q;
    last_col_d = last_col_q;
`ifdef SHOTS_LIMIT_EN
    lose_d     = lose_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_fleet) begin
          fleet_d  = fleet_in;
          attack_d = '0;
          status_d = ST_NONE;
          win_d    = 1'b0;
`ifdef SHOTS_LIMIT_EN
          lose_d   = 1'b0;
`endif
        end else if (button_confirmation) begin
          last_row_d = coord_row;
          last_col_d = coord_col;
          busy_d     = 1'b1;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (!sel_valid || |(attack_q & sel_mask)) cls_d = ST_REP;
        else if (|(fleet_q & sel_mask))           cls_d = ST_HIT;
        else                                      cls_d = ST_MISS;
        state_d = UPDATE;
      end
      UPDATE: begin
        status_d = cls_q;
        busy_d   = 1'b0;
        state_d  = IDLE;
        if (shot_valid) begin
          attack_d   = attack_q | sel_mask;
          shot_cnt_d = (shot_cnt_q == 8'hFF) ? shot_cnt_q : shot_cnt_q + 8'd1;
        end
        if ((fleet_q != '0) && ((fleet_q & ~attack_d) == '0)) begin
          win_d   = 1'b1;
          state_d = DONE;
        end
`ifdef SHOTS_LIMIT_EN
        else if (shot_valid && (({1'b0, shot_cnt_q} + 9'd1) == 9'(MAX_SHOTS))) begin
          lose_d  = 1'b1;
          state_d = DONE;
        end
`endif
      end
      default: ;
    endcase
    // Clear overrides everything, including a shot still in flight; the fleet map survives.
    if (button_clear) begin
      attack_d   = '0;
      status_d   = ST_NONE;
      win_d      = 1'b0;
      shot_cnt_d = '0;
      busy_d     = 1'b0;
      state_d    = IDLE;
`ifdef SHOTS_LIMIT_EN
      lose_d     = 1'b0;
`endif
    end
  end

  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    col_d   = col_q;
    dig_d   = dig_q;
    if (tick) begin
      col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
      dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      fleet_q    <= '0;
      attack_q   <= '0;
      status_q   <= ST_NONE;
      cls_q      <= ST_NONE;
      busy_q     <= 1'b0;
      win_q      <= 1'b0;
      shot_cnt_q <= '0;
      last_row_q <= '0;
      last_col_q <= '0;
      presc_q    <= '0;
      col_q      <= '0;
      dig_q      <= '0;
`ifdef SHOTS_LIMIT_EN
      lose_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fleet_q    <= fleet_d;
      attack_q   <= attack_d;
      status_q   <= status_d;
      cls_q      <= cls_d;
      busy_q     <= busy_d;
      win_q      <= win_d;
      shot_cnt_q <= shot_cnt_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
      presc_q    <= presc_d;
      col_q      <= col_d;
      dig_q      <= dig_d;
`ifdef SHOTS_LIMIT_EN
      lose_q     <= lose_d;
`endif
    end
  end

  // Each matrix row line shows the cell of that row in the currently scanned column.
  for (genvar r = 0; r < ROWS; r++) begin : g_line
    logic [COLS-1:0] f_row;
    logic [COLS-1:0] a_row;
    assign f_row          = fleet_q[r*COLS +: COLS];
    assign a_row          = attack_q[r*COLS +: COLS];
    assign m_line_hit[r]  = f_row[col_q] & a_row[col_q];
    assign m_line_miss[r] = ~f_row[col_q] & a_row[col_q];
  end

  always_comb begin
    case (dig_q)
      2'd0:    dig_val = {2'b00, status_q};
      2'd1:    dig_val = {1'b0, last_row_q};
      2'd2:    dig_val = {1'b0, last_col_q};
      default: dig_val = 4'd0;
    endcase
  end

  assign status  = status_q;
  assign busy    = busy_q;
  assign win     = win_q;
  assign m_col   = {{(COLS-1){1'b0}}, 1'b1} << col_q;
  assign dig_sel = 3'b001 << dig_q;
`ifdef SHOTS_LIMIT_EN
  assign lose    = lose_q;
`else
  // No budget in this build: MAX_SHOTS has no effect and this folds to a constant 0.
  assign lose    = (MAX_SHOTS < 0);
`endif

endmodule

// File: tb/tb_battle_board_ctrl.sv
// Self-checking bench for battle_board_ctrl: directed scenarios followed by randomized play,
// every output compared each cycle against a board-level reference model.
module tb_battle_board_ctrl;

   localparam int ROWS      = 7;
   localparam int COLS      = 5;
   localparam int SCAN_DIV  = 4;
   localparam int MAX_SHOTS = 5;
   localparam int N         = ROWS * COLS;

   localparam int OP_IDLE       = 0;
   localparam int OP_FIRE       = 1;
   localparam int OP_LOAD       = 2;
   localparam int OP_CLEAR      = 3;
   localparam int OP_LOAD_FIRE  = 4;
   localparam int OP_FIRE_CLEAR = 5;
   localparam int OP_FIRE_TWICE = 6;

   logic            clk = 1'b0;
   logic            clr = 1'b1;
   logic            button_clear = 1'b0;
   logic            load_fleet = 1'b0;
   logic [N-1:0]    fleet_in = '0;
   logic            button_confirmation = 1'b0;
   logic [2:0]      coord_row = 3'd0;
   logic [2:0]      coord_col = 3'd0;
   logic [1:0]      status;
   logic            busy;
   logic            win;
   logic            lose;
   logic [COLS-1:0] m_col;
   logic [ROWS-1:0] m_line_hit;
   logic [ROWS-1:0] m_line_miss;
   logic [2:0]      dig_sel;
   logic [3:0]      dig_val;

   int checks = 0;
   int errors = 0;
   int edgeCount = 0;

   // Reference model: the board as two 2-D cell arrays plus the visible game state.
   bit         mFleet [ROWS][COLS];
   bit         mAtk   [ROWS][COLS];
   logic [1:0] mStatus;
   bit         mBusy, mWin, mLose, mDone;
   int         mShots;
   logic [2:0] mLastRow, mLastCol;

   battle_board_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .MAX_SHOTS(MAX_SHOTS)
   ) dut (
      .clk(clk), .clr(clr), .button_clear(button_clear), .load_fleet(load_fleet),
      .fleet_in(fleet_in), .button_confirmation(button_confirmation),
      .coord_row(coord_row), .coord_col(coord_col), .status(status), .busy(busy),
      .win(win), .lose(lose), .m_col(m_col), .m_line_hit(m_line_hit),
      .m_line_miss(m_line_miss), .dig_sel(dig_sel), .dig_val(dig_val)
   );

   // Free-running 100 MHz-style clock.
   always #5 clk = ~clk;

   // Count clock edges since reset release; the scan position follows from this alone.
   always @(posedge clk or negedge clr) begin
      if (!clr) edgeCount <= 0;
      else      edgeCount <= edgeCount + 1;
   end

   // Single comparison point: counts the check and reports any difference.
   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reset the whole model, including the fleet and the last target.
   function automatic void modelReset();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            mFleet[r][c] = 1'b0;
            mAtk[r][c]   = 1'b0;
         end
      mStatus = 2'b00; mBusy = 0; mWin = 0; mLose = 0; mDone = 0; mShots = 0;
      mLastRow = 3'd0; mLastCol = 3'd0;
   endfunction

   // Game clear keeps the fleet and the last target but restarts the game.
   function automatic void modelClear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) mAtk[r][c] = 1'b0;
      mStatus = 2'b00; mBusy = 0; mWin = 0; mLose = 0; mDone = 0; mShots = 0;
   endfunction

   // Loading a new fleet wipes the attack map and the outcome flags.
   function automatic void modelLoad(input logic [N-1:0] vec);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            mFleet[r][c] = vec[r*COLS + c];
            mAtk[r][c]   = 1'b0;
         end
      mStatus = 2'b00; mWin = 0; mLose = 0;
   endfunction

   // Resolve one accepted shot directly from the game rules.
   function automatic void modelResolve(input int row, input int col);
      int fleetCells;
      int remaining;
      logic [1:0] st;
`ifdef SHOTS_LIMIT_EN
      int shotsBefore;
      shotsBefore = mShots;
`endif
      if (row >= ROWS || col >= COLS) st = 2'b11;
      else if (mAtk[row][col])        st = 2'b11;
      else                            st = mFleet[row][col] ? 2'b10 : 2'b01;
      mStatus = st;
      if (st != 2'b11) begin
         mAtk[row][col] = 1'b1;
         if (mShots < 255) mShots++;
      end
      fleetCells = 0;
      remaining  = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (mFleet[r][c]) begin
               fleetCells++;
               if (!mAtk[r][c]) remaining++;
            end
      if (fleetCells > 0 && remaining == 0) begin
         mWin = 1; mDone = 1;
      end
`ifdef SHOTS_LIMIT_EN
      else if (st != 2'b11 && shotsBefore + 1 == MAX_SHOTS) begin
         mLose = 1; mDone = 1;
      end
`endif
   endfunction

   // Compare every output against the model; scan position derives from elapsed edges.
   task automatic checkOutput(input string where);
      int scanStep;
      int col;
      int dig;
      logic [ROWS-1:0] expHit;
      logic [ROWS-1:0] expMiss;
      logic [3:0] expDig;
      scanStep = edgeCount / SCAN_DIV;
      col      = scanStep % COLS;
      dig      = scanStep % 3;
      for (int r = 0; r < ROWS; r++) begin
         expHit[r]  = mFleet[r][col] & mAtk[r][col];
         expMiss[r] = !mFleet[r][col] & mAtk[r][col];
      end
      case (dig)
         0:       expDig = {2'b00, mStatus};
         1:       expDig = {1'b0, mLastRow};
         default: expDig = {1'b0, mLastCol};
      endcase
      checkVal({where, " status"},      32'(status),      32'(mStatus));
      checkVal({where, " busy"},        32'(busy),        32'(mBusy));
      checkVal({where, " win"},         32'(win),         32'(mWin));
      checkVal({where, " lose"},        32'(lose),        32'(mLose));
      checkVal({where, " m_col"},       32'(m_col),       32'(1) << col);
      checkVal({where, " m_line_hit"},  32'(m_line_hit),  32'(expHit));
      checkVal({where, " m_line_miss"}, 32'(m_line_miss), 32'(expMiss));
      checkVal({where, " dig_sel"},     32'(dig_sel),     32'(1) << dig);
      checkVal({where, " dig_val"},     32'(dig_val),     32'(expDig));
   endtask

   // Advance one clock and check; inputs change only on the falling edge.
   task automatic step(input string where);
      @(posedge clk);
      @(negedge clk);
      checkOutput(where);
   endtask

   // Drive one operation, updating the model to the state expected after each edge.
   task automatic applyStimulus(input int op, input int row, input int col, input logic [N-1:0] vec);
      bit accepted;
      case (op)
         OP_IDLE: step("idle");
         OP_CLEAR: begin
            button_clear = 1'b1;
            modelClear();
            step("clear");
            button_clear = 1'b0;
         end
         OP_LOAD, OP_LOAD_FIRE: begin
            fleet_in   = vec;
            load_fleet = 1'b1;
            if (op == OP_LOAD_FIRE) begin
               coord_row = row[2:0];
               coord_col = col[2:0];
               button_confirmation = 1'b1;
            end
            if (!mDone) modelLoad(vec);
            step("load");
            load_fleet = 1'b0;
            button_confirmation = 1'b0;
            step("after load");
         end
         default: begin
            coord_row = row[2:0];
            coord_col = col[2:0];
            button_confirmation = 1'b1;
            accepted = !mDone;
            if (accepted) begin
               mLastRow = row[2:0];
               mLastCol = col[2:0];
               mBusy    = 1;
            end
            step("confirm");
            button_confirmation = 1'b0;
            if (op == OP_FIRE_CLEAR) begin
               button_clear = 1'b1;
               modelClear();
               step("abandon");
               button_clear = 1'b0;
            end else begin
               if (op == OP_FIRE_TWICE) begin
                  coord_row = 3'($urandom_range(0, 7));
                  coord_col = 3'($urandom_range(0, 7));
                  button_confirmation = 1'b1;
               end
               step("check");
               button_confirmation = 1'b0;
               if (accepted) begin
                  modelResolve(row, col);
                  mBusy = 0;
               end
               step("update");
            end
         end
      endcase
   endtask

   // Directed scenarios first, then randomized play against the model.
   initial begin
      logic [N-1:0] vec;
      int sel;
      int row;
      int col;
      int op;

      #1 clr = 1'b0;
      #1;
      modelReset();
      checkOutput("power-on reset");
      @(negedge clk);
      clr = 1'b1;
      for (int i = 0; i < 7; i++) applyStimulus(OP_IDLE, 0, 0, '0);

      #2 clr = 1'b0;
      #1;
      modelReset();
      checkOutput("async reset mid-scan");
      @(negedge clk);
      checkOutput("held in reset");
      clr = 1'b1;

      vec = '0;
      vec[0] = 1'b1;
      vec[7] = 1'b1;
      applyStimulus(OP_LOAD, 0, 0, vec);
      applyStimulus(OP_FIRE, 0, 0, '0);
      applyStimulus(OP_FIRE, 0, 1, '0);
      applyStimulus(OP_FIRE, 0, 0, '0);
      applyStimulus(OP_FIRE, 7, 2, '0);
      applyStimulus(OP_FIRE, 2, 5, '0);
      applyStimulus(OP_FIRE, 1, 2, '0);
      applyStimulus(OP_FIRE, 0, 3, '0);
      applyStimulus(OP_LOAD, 0, 0, '1);
      applyStimulus(OP_CLEAR, 0, 0, '0);
      applyStimulus(OP_FIRE, 0, 0, '0);
      applyStimulus(OP_FIRE, 0, 1, '0);
      applyStimulus(OP_LOAD_FIRE, 1, 2, vec);
      applyStimulus(OP_FIRE, 0, 0, '0);
      applyStimulus(OP_FIRE, 0, 1, '0);
      for (int i = 0; i < 4 * COLS; i++) applyStimulus(OP_IDLE, 0, 0, '0);
      applyStimulus(OP_FIRE_CLEAR, 1, 2, '0);

`ifdef SHOTS_LIMIT_EN
      applyStimulus(OP_FIRE, 6, 4, '0);
      applyStimulus(OP_FIRE, 6, 3, '0);
      applyStimulus(OP_FIRE, 6, 3, '0);
      applyStimulus(OP_FIRE, 6, 2, '0);
      applyStimulus(OP_FIRE, 6, 1, '0);
      applyStimulus(OP_FIRE, 6, 0, '0);
      applyStimulus(OP_FIRE, 5, 0, '0);
      applyStimulus(OP_CLEAR, 0, 0, '0);
`endif

      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 19);
         if ($urandom_range(0, 3) == 0) begin
            row = $urandom_range(0, 7);
            col = $urandom_range(0, 7);
         end else begin
            row = $urandom_range(0, ROWS - 1);
            col = $urandom_range(0, COLS - 1);
         end
         if ($urandom_range(0, 2) == 0) begin
            for (int t = 0; t < 8; t++) begin
               if (row < ROWS && col < COLS && mFleet[row][col]) break;
               row = $urandom_range(0, ROWS - 1);
               col = $urandom_range(0, COLS - 1);
            end
         end
         for (int b = 0; b < N; b++) vec[b] = ($urandom_range(0, 15) == 0);
         case (sel)
            0:       op = OP_CLEAR;
            1:       op = OP_LOAD;
            2:       op = OP_LOAD_FIRE;
            3:       op = OP_FIRE_CLEAR;
            4:       op = OP_FIRE_TWICE;
            5:       op = OP_IDLE;
            default: op = OP_FIRE;
         endcase
         applyStimulus(op, row, col, vec);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
